// File: rtl/vdp_host_port_if.sv
// Host-bus, VRAM-arbiter and register-file signals of the VDP host port.
// The slave modport is the port logic. The master modport is the host/arbiter side.
interface vdp_host_port_if #(
    parameter int RamBits = 16,
    parameter int RegBits = 3
);
    logic               cs;
    logic               wr;
    logic               rd;
    logic [1:0]         port;
    logic [7:0]         cpuDataIn;
    logic [7:0]         cpuDataOut;
    logic               cpuReady;
    logic               memReq;
    logic               memWe;
    logic [RamBits-1:0] memAddr;
    logic [7:0]         memDataOut;
    logic               memAck;
    logic [7:0]         memDataIn;
    logic               regWe;
    logic [RegBits-1:0] regIndex;
    logic [7:0]         regData;

    modport slave (
        input  cs, wr, rd, port, cpuDataIn, memAck, memDataIn,
        output cpuDataOut, cpuReady, memReq, memWe, memAddr, memDataOut,
        output regWe, regIndex, regData
    );

    modport master (
        output cs, wr, rd, port, cpuDataIn, memAck, memDataIn,
        input  cpuDataOut, cpuReady, memReq, memWe, memAddr, memDataOut,
        input  regWe, regIndex, regData
    );
endinterface

// File: rtl/vdp_host_port.sv
// CPU front end of the VDP: VRAM access with auto-increment and one-byte read-ahead,
// plus one-cycle write pulses into the VDP register file.
module vdp_host_port #(
    parameter int RamBits = 16,
    parameter int RegBits = 3
) (
    input  logic            clk,
    input  logic            reset,
    vdp_host_port_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MEMWR = 2'd1;
    localparam logic [1:0] MEMRD = 2'd2;

    localparam logic [RamBits-1:0] ADDR_ONE = 1;
    localparam logic [RegBits-1:0] IDX_ONE  = 1;

    logic [1:0]         state_q,     state_d;
    logic [RamBits-1:0] addr_q,      addr_d;
    logic [7:0]         addr_lo_q,   addr_lo_d;
    logic               hi_next_q,   hi_next_d;
    logic               overrun_q,   overrun_d;
    logic [7:0]         prefetch_q,  prefetch_d;
    logic               mem_we_q,    mem_we_d;
    logic [7:0]         mem_data_q,  mem_data_d;
    logic [7:0]         cpu_dout_q,  cpu_dout_d;
    logic               reg_we_q,    reg_we_d;
    logic [RegBits-1:0] reg_index_q, reg_index_d;
    logic [7:0]         reg_data_q,  reg_data_d;

    logic        idle;
    logic        wr_acc;
    logic        rd_acc;
    logic [15:0] full_addr;

    assign idle      = (state_q == IDLE);
    assign wr_acc    = bus.cs & bus.wr;
    assign rd_acc    = bus.cs & bus.rd & ~bus.wr;
    assign full_addr = {bus.cpuDataIn, addr_lo_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        addr_lo_d   = addr_lo_q;
        hi_next_d   = hi_next_q;
        overrun_d   = overrun_q;
        prefetch_d  = prefetch_q;
        mem_we_d    = mem_we_q;
        mem_data_d  = mem_data_q;
        cpu_dout_d  = cpu_dout_q;
        reg_we_d    = 1'b0;
        reg_index_d = reg_index_q;
        reg_data_d  = reg_data_q;

        // Completion of the outstanding request; new requests are only accepted in IDLE,
        // so this never collides with an acceptance below.
        if (!idle && bus.memAck) begin
            state_d = IDLE;
            addr_d  = addr_q + ADDR_ONE;
            if (state_q == MEMRD) begin
                prefetch_d = bus.memDataIn;
            end
        end

        if (reg_we_q) begin
            reg_index_d = reg_index_q + IDX_ONE;
        end

        if (wr_acc) begin
            case (bus.port)
                2'd0: begin
                    if (idle) begin
                        mem_we_d   = 1'b1;
                        mem_data_d = bus.cpuDataIn;
                        state_d    = MEMWR;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                2'd1: begin
                    if (!hi_next_q) begin
                        addr_lo_d = bus.cpuDataIn;
                        hi_next_d = 1'b1;
                    end else if (idle) begin
                        addr_d    = RamBits'(full_addr);
                        hi_next_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = MEMRD;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                2'd2: reg_index_d = bus.cpuDataIn[RegBits-1:0];
                default: begin
                    reg_we_d   = 1'b1;
                    reg_data_d = bus.cpuDataIn;
                end
            endcase
        end else if (rd_acc) begin
            case (bus.port)
                2'd0: begin
                    if (idle) begin
                        cpu_dout_d = prefetch_q;
                        mem_we_d   = 1'b0;
                        state_d    = MEMRD;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                2'd1: begin
                    cpu_dout_d = {idle, overrun_q, hi_next_q, 5'b0};
                    overrun_d  = 1'b0;
                    hi_next_d  = 1'b0;
                end
                2'd2:    cpu_dout_d = 8'(reg_index_q);
                default: cpu_dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            addr_lo_q   <= '0;
            hi_next_q   <= 1'b0;
            overrun_q   <= 1'b0;
            prefetch_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_data_q  <= '0;
            cpu_dout_q  <= '0;
            reg_we_q    <= 1'b0;
            reg_index_q <= '0;
            reg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addr_lo_q   <= addr_lo_d;
            hi_next_q   <= hi_next_d;
            overrun_q   <= overrun_d;
            prefetch_q  <= prefetch_d;
            mem_we_q    <= mem_we_d;
            mem_data_q  <= mem_data_d;
            cpu_dout_q  <= cpu_dout_d;
            reg_we_q    <= reg_we_d;
            reg_index_q <= reg_index_d;
            reg_data_q  <= reg_data_d;
        end
    end

    // addr only moves on acceptance or ack, so it doubles as the request address.
    assign bus.memReq     = ~idle;
    assign bus.memWe      = mem_we_q;
    assign bus.memAddr    = addr_q;
    assign bus.memDataOut = mem_data_q;
    assign bus.cpuReady   = idle;
    assign bus.cpuDataOut = cpu_dout_q;
    assign bus.regWe      = reg_we_q;
    assign bus.regIndex   = reg_index_q;
    assign bus.regData    = reg_data_q;
endmodule

// File: tb/tb_vdp_host_port.sv
// Directed bench for vdp_host_port: a vector table of single host accesses
// plus hand-written sequences for overrun, address latch and asynchronous reset.
module tb_vdp_host_port;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    vdp_host_port_if #(.RamBits(16), .RegBits(3)) bus ();

    vdp_host_port #(.RamBits(16), .RegBits(3)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  port;
        logic        wr;
        logic        rd;
        logic [7:0]  din;
        logic        ack;
        logic [7:0]  ack_data;
        logic        exp_req;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_mdata;
        logic [7:0]  exp_dout;
        logic        exp_regwe;
        logic [2:0]  exp_idx;
        logic [7:0]  exp_rdata;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [1:0] p, input logic w, input logic r, input logic [7:0] d,
        input logic a, input logic [7:0] ad,
        input logic req, input logic we, input logic [15:0] addr, input logic [7:0] md,
        input logic [7:0] dout, input logic rwe, input logic [2:0] idx, input logic [7:0] rd_data);
        vec_t v;
        v.port = p; v.wr = w; v.rd = r; v.din = d; v.ack = a; v.ack_data = ad;
        v.exp_req = req; v.exp_we = we; v.exp_addr = addr; v.exp_mdata = md;
        v.exp_dout = dout; v.exp_regwe = rwe; v.exp_idx = idx; v.exp_rdata = rd_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One strobe cycle; returns at the falling edge of the cycle after acceptance.
    task automatic access(input logic [1:0] p, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.wr = w; bus.rd = r; bus.port = p; bus.cpuDataIn = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.cpuDataIn = 8'h00;
    endtask

    task automatic do_ack(input logic [7:0] d);
        bus.memAck = 1'b1; bus.memDataIn = d;
        @(negedge clk);
        bus.memAck = 1'b0; bus.memDataIn = 8'h00;
        check("ack memReq", {15'd0, bus.memReq}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.port = 2'd0;
        bus.cpuDataIn = 8'h00; bus.memAck = 1'b0; bus.memDataIn = 8'h00;

        //            port wr rd din    ack ackd   req we addr      mdata  dout   rwe idx   rdata
        vecs[0]  = mk(2'd1, 1, 0, 8'h34, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 3'd0, 8'h00);
        vecs[1]  = mk(2'd1, 1, 0, 8'h12, 1, 8'hAB, 1, 0, 16'h1234, 8'h00, 8'h00, 0, 3'd0, 8'h00);
        vecs[2]  = mk(2'd0, 0, 1, 8'h00, 1, 8'hCD, 1, 0, 16'h1235, 8'h00, 8'hAB, 0, 3'd0, 8'h00);
        vecs[3]  = mk(2'd0, 0, 1, 8'h00, 1, 8'hEF, 1, 0, 16'h1236, 8'h00, 8'hCD, 0, 3'd0, 8'h00);
        vecs[4]  = mk(2'd0, 1, 0, 8'h77, 1, 8'h00, 1, 1, 16'h1237, 8'h77, 8'hCD, 0, 3'd0, 8'h00);
        vecs[5]  = mk(2'd0, 0, 1, 8'h00, 1, 8'h11, 1, 0, 16'h1238, 8'h00, 8'hEF, 0, 3'd0, 8'h00);
        vecs[6]  = mk(2'd1, 1, 0, 8'hFE, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'hEF, 0, 3'd0, 8'h00);
        vecs[7]  = mk(2'd1, 1, 0, 8'hFF, 1, 8'h99, 1, 0, 16'hFFFE, 8'h00, 8'hEF, 0, 3'd0, 8'h00);
        vecs[8]  = mk(2'd0, 1, 0, 8'h5A, 1, 8'h00, 1, 1, 16'hFFFF, 8'h5A, 8'hEF, 0, 3'd0, 8'h00);
        vecs[9]  = mk(2'd0, 1, 0, 8'h3C, 1, 8'h00, 1, 1, 16'h0000, 8'h3C, 8'hEF, 0, 3'd0, 8'h00);
        vecs[10] = mk(2'd1, 0, 1, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h80, 0, 3'd0, 8'h00);
        vecs[11] = mk(2'd2, 1, 0, 8'h06, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h80, 0, 3'd6, 8'h00);
        vecs[12] = mk(2'd2, 0, 1, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h06, 0, 3'd6, 8'h00);
        vecs[13] = mk(2'd3, 1, 0, 8'h11, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h06, 1, 3'd6, 8'h11);
        vecs[14] = mk(2'd3, 1, 0, 8'h22, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h06, 1, 3'd7, 8'h22);
        vecs[15] = mk(2'd3, 0, 1, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 3'd0, 8'h00);
        vecs[16] = mk(2'd2, 1, 0, 8'h0D, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 3'd5, 8'h00);
        vecs[17] = mk(2'd2, 0, 1, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 8'h05, 0, 3'd5, 8'h00);
        vecs[18] = mk(2'd0, 1, 1, 8'h44, 1, 8'h00, 1, 1, 16'h0001, 8'h44, 8'h05, 0, 3'd5, 8'h00);
        vecs[19] = mk(2'd0, 0, 1, 8'h00, 1, 8'h55, 1, 0, 16'h0002, 8'h00, 8'h99, 0, 3'd5, 8'h00);

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cpuReady",   {15'd0, bus.cpuReady}, 16'd1);
        check("reset memReq",     {15'd0, bus.memReq},   16'd0);
        check("reset regWe",      {15'd0, bus.regWe},    16'd0);
        check("reset cpuDataOut", {8'd0, bus.cpuDataOut}, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            access(vecs[i].port, vecs[i].wr, vecs[i].rd, vecs[i].din);
            $display("[TB] vec %0d port=%0d wr=%0d rd=%0d din=%h -> req=%0d we=%0d addr=%h dout=%h regWe=%0d idx=%0d",
                     i, vecs[i].port, vecs[i].wr, vecs[i].rd, vecs[i].din, bus.memReq, bus.memWe,
                     bus.memAddr, bus.cpuDataOut, bus.regWe, bus.regIndex);
            check($sformatf("v%0d memReq", i), {15'd0, bus.memReq}, {15'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d memWe", i), {15'd0, bus.memWe}, {15'd0, vecs[i].exp_we});
                check($sformatf("v%0d memAddr", i), bus.memAddr, vecs[i].exp_addr);
                if (vecs[i].exp_we)
                    check($sformatf("v%0d memDataOut", i), {8'd0, bus.memDataOut}, {8'd0, vecs[i].exp_mdata});
            end
            check($sformatf("v%0d cpuDataOut", i), {8'd0, bus.cpuDataOut}, {8'd0, vecs[i].exp_dout});
            check($sformatf("v%0d regWe", i), {15'd0, bus.regWe}, {15'd0, vecs[i].exp_regwe});
            if (vecs[i].exp_regwe)
                check($sformatf("v%0d regData", i), {8'd0, bus.regData}, {8'd0, vecs[i].exp_rdata});
            check($sformatf("v%0d regIndex", i), {13'd0, bus.regIndex}, {13'd0, vecs[i].exp_idx});
            if (vecs[i].ack) do_ack(vecs[i].ack_data);
        end

        // Overrun: second port 0 write while MEMWR is stalled must be dropped.
        access(2'd0, 1'b1, 1'b0, 8'h66);
        $display("[TB] seq overrun first write req=%0d addr=%h data=%h", bus.memReq, bus.memAddr, bus.memDataOut);
        check("ovr first memReq",  {15'd0, bus.memReq}, 16'd1);
        check("ovr first memAddr", bus.memAddr, 16'h0003);
        check("ovr first memData", {8'd0, bus.memDataOut}, 16'h0066);
        access(2'd0, 1'b1, 1'b0, 8'h67);
        $display("[TB] seq overrun dropped write req=%0d addr=%h data=%h", bus.memReq, bus.memAddr, bus.memDataOut);
        check("ovr drop memData", {8'd0, bus.memDataOut}, 16'h0066);
        check("ovr drop memAddr", bus.memAddr, 16'h0003);
        access(2'd1, 1'b0, 1'b1, 8'h00);
        $display("[TB] seq status read dout=%h", bus.cpuDataOut);
        check("ovr status 1", {8'd0, bus.cpuDataOut}, 16'h0040);
        access(2'd1, 1'b0, 1'b1, 8'h00);
        $display("[TB] seq status read dout=%h", bus.cpuDataOut);
        check("ovr status 2", {8'd0, bus.cpuDataOut}, 16'h0000);
        do_ack(8'h00);
        access(2'd0, 1'b0, 1'b1, 8'h00);
        $display("[TB] seq read after overrun dout=%h addr=%h", bus.cpuDataOut, bus.memAddr);
        check("ovr post dout", {8'd0, bus.cpuDataOut}, 16'h0055);
        check("ovr post addr", bus.memAddr, 16'h0004);
        check("ovr post memWe", {15'd0, bus.memWe}, 16'd0);
        do_ack(8'h21);

        // Status read clears hiNext, so the next port 1 write is a low byte again.
        access(2'd1, 1'b1, 1'b0, 8'h10);
        access(2'd1, 1'b0, 1'b1, 8'h00);
        $display("[TB] seq hiNext status dout=%h", bus.cpuDataOut);
        check("hinext status", {8'd0, bus.cpuDataOut}, 16'h00A0);
        access(2'd1, 1'b1, 1'b0, 8'h20);
        check("hinext lo memReq", {15'd0, bus.memReq}, 16'd0);
        access(2'd1, 1'b1, 1'b0, 8'h00);
        $display("[TB] seq address latch req=%0d addr=%h", bus.memReq, bus.memAddr);
        check("hinext hi memReq", {15'd0, bus.memReq}, 16'd1);
        check("hinext hi addr", bus.memAddr, 16'h0020);
        do_ack(8'h00);

        // Asynchronous reset in the middle of a write request.
        access(2'd0, 1'b1, 1'b0, 8'h5A);
        check("rst pre memReq", {15'd0, bus.memReq}, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] seq async reset req=%0d ready=%0d dout=%h", bus.memReq, bus.cpuReady, bus.cpuDataOut);
        check("rst memReq",   {15'd0, bus.memReq}, 16'd0);
        check("rst cpuReady", {15'd0, bus.cpuReady}, 16'd1);
        check("rst memWe",    {15'd0, bus.memWe}, 16'd0);
        check("rst regIndex", {13'd0, bus.regIndex}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        access(2'd1, 1'b0, 1'b1, 8'h00);
        check("rst status", {8'd0, bus.cpuDataOut}, 16'h0080);
        access(2'd0, 1'b0, 1'b1, 8'h00);
        $display("[TB] seq read after reset dout=%h addr=%h", bus.cpuDataOut, bus.memAddr);
        check("rst prefetch", {8'd0, bus.cpuDataOut}, 16'h0000);
        check("rst addr", bus.memAddr, 16'h0000);
        do_ack(8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vdp_host_port.md
Name: vdp_host_port

Overview:
- CPU-side write/read front end of the VDP.
- Takes 8-bit host bus strobes on four ports: data, address/status, register select and register data.
- Turns them into VRAM read/write requests for the VDP RAM arbiter, with auto-increment and a one-byte read-ahead buffer.
- Drives one-cycle write pulses into the VDP register file. It is the writer side for the memory and registers the display pipeline reads.

Parameters:
- RamBits, 16, VRAM address width (64Kb default).
- RegBits, 3, width of the register index (8 VDP registers).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- cs  input  1  chip select, qualifies wr/rd.
- wr  input  1  write strobe, sampled when cs=1.
- rd  input  1  read strobe, sampled when cs=1.
- port  input  2  0=data, 1=address/status, 2=register select, 3=register data.
- cpuDataIn  input  8  host write data.
- cpuDataOut  output  8  host read data, registered.
- cpuReady  output  1  1 = no VRAM transaction pending.
- memReq  output  1  VRAM request, held until memAck.
- memWe  output  1  1 = write request, 0 = read request.
- memAddr  output  RamBits  VRAM address of the current request.
- memDataOut  output  8  VRAM write data.
- memAck  input  1  arbiter completion, one cycle; only meaningful while memReq=1.
- memDataIn  input  8  VRAM read data, valid with memAck on reads.
- regWe  output  1  one-cycle register write pulse.
- regIndex  output  RegBits  target register index.
- regData  output  8  register write value.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0 except cpuReady=1.
  - Internal address, addrLo, hiNext, overrun, prefetch buffer and state all cleared.
  - Any request in flight is abandoned; memReq drops immediately.
- Access decode, per cycle with cs=1:
  - wr=1 is a write access. If rd=1 as well, wr wins and rd is ignored.
  - Each strobe cycle is one access; hosts pulse strobes for one cycle.
- State machine: IDLE, MEMWR, MEMRD.
  - cpuReady = (state==IDLE).
  - A request is accepted at cycle T. memReq, memWe, memAddr and memDataOut are valid from T+1 until the cycle memAck=1. The state returns to IDLE on the next edge.
- Port 0 write, in IDLE: memWe=1, memAddr=addr, memDataOut=data, enter MEMWR. On memAck, addr <= addr+1. The prefetch buffer is left unchanged (stale).
- Port 0 read, in IDLE:
  - cpuDataOut <= prefetch at T+1.
  - Then memWe=0, memAddr=addr, enter MEMRD.
  - On memAck: prefetch <= memDataIn and addr <= addr+1.
- Port 1 write:
  - hiNext=0: addrLo <= data, hiNext <= 1. Allowed even when busy.
  - hiNext=1 and IDLE: addr <= {data, addrLo} truncated to RamBits, hiNext <= 0, then start a prefetch read as for a port 0 read, but without updating cpuDataOut.
- Port 1 read: cpuDataOut <= {cpuReady, overrun, hiNext, 5'b0}; overrun <= 0 and hiNext <= 0 on the same edge.
- Port 2 write: regIndex <= data[RegBits-1:0]. Port 2 read returns the index zero-extended.
- Port 3 write:
  - regWe=1 for exactly one cycle (T+1), with regData=data and regIndex at its current value.
  - regIndex increments modulo 2^RegBits on the cycle after the pulse.
  - Port 3 read returns 8'h00.
- Busy conflicts: a port 0 access, or a port 1 high-byte write, while state!=IDLE is dropped.
  - overrun <= 1.
  - addr, prefetch, cpuDataOut and hiNext are unchanged.
  - Ports 2 and 3 and the port 1 low-byte write are never blocked.
- Address arithmetic: addr wraps modulo 2^RamBits (0xFFFF+1 -> 0x0000 at the default width).
- memAck while memReq=0 is ignored.

Test Plan:
- Reset then idle: cpuReady=1, memReq=0, regWe=0, cpuDataOut=0x00. Assert reset mid-MEMWR: memReq drops in the same cycle.
- Port 1 writes 0x34 then 0x12: memReq with memWe=0, memAddr=0x1234. Ack with memDataIn=0xAB. Port 0 read then returns 0xAB and issues a read at 0x1235.
- After addr=0xFFFF, port 0 write 0x5A: memWe=1, memAddr=0xFFFF, memDataOut=0x5A. After ack the next write goes to 0x0000.
- Port 2 write 0x06, then port 3 writes 0x11 and 0x22: regWe pulses with (6, 0x11) then (7, 0x22). regIndex ends at 0.
- Hold memAck low after a port 0 write, then issue a second port 0 write: it is dropped and no second request occurs. A port 1 read returns bit6=1 (0x40 with cpuReady=0); a following port 1 read returns 0x00 in bit6.
- cs=1 with wr=1 and rd=1 on port 0: only the write occurs. cpuDataOut is unchanged and no read is issued.
